// File: rtl/edge_pkg.sv
// Shared types for the edge operand network: test opcodes and the operand
// word carried to reservation-station slots.
package edge_pkg;

    localparam int EDGE_DATA_W = 32;

    typedef enum logic [2:0] {
        TEQ  = 3'd0,
        TNE  = 3'd1,
        TLT  = 3'd2,
        TLE  = 3'd3,
        TGT  = 3'd4,
        TGE  = 3'd5,
        TLTU = 3'd6,
        TGEU = 3'd7
    } test_op_e;

    typedef struct packed {
        logic                   valid;
        logic [EDGE_DATA_W-1:0] data;
    } operand_t;

endpackage

// File: rtl/pred_generator_if.sv
// Test-instruction intake and predicate-operand output bundle of pred_generator.
// slave is the generator's view, master is the surrounding pipeline's view.
interface pred_generator_if
    import edge_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TGT_W  = 8
) ();

    logic              in_valid;
    logic              in_ready;
    test_op_e          in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [1:0]        in_num_tgt;
    logic [TGT_W-1:0]  in_tgt0;
    logic [TGT_W-1:0]  in_tgt1;

    logic              out_valid;
    logic              out_ready;
    logic [TGT_W-1:0]  out_tgt;
    operand_t          out_operand;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_num_tgt, in_tgt0, in_tgt1, out_ready,
        output in_ready, out_valid, out_tgt, out_operand
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_num_tgt, in_tgt0, in_tgt1, out_ready,
        input  in_ready, out_valid, out_tgt, out_operand
    );

endinterface

// File: rtl/pred_compare.sv
// Purely combinational test evaluator: signed/unsigned magnitude and equality
// comparisons producing a single predicate bit.
module pred_compare
    import edge_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  test_op_e          op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              result
);

    // Select the comparison requested by the opcode.
    always_comb begin
        result = 1'b0;
        case (op)
            TEQ:     result = (a == b);
            TNE:     result = (a != b);
            TLT:     result = ($signed(a) <  $signed(b));
            TLE:     result = ($signed(a) <= $signed(b));
            TGT:     result = ($signed(a) >  $signed(b));
            TGE:     result = ($signed(a) >= $signed(b));
            TLTU:    result = (a <  b);
            TGEU:    result = (a >= b);
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/pred_generator.sv
// Evaluates a test instruction and fans its predicate out to up to two
// operand targets, one network handshake per target.
module pred_generator
    import edge_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TGT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pred_generator_if.slave  bus,
    output logic             err_illegal,
    output logic [15:0]      sent_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND0 = 2'd1;
    localparam logic [1:0] ST_SEND1 = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic             two_tgt_r;
    logic [TGT_W-1:0] tgt1_r;
    logic             out_valid_r;
    logic [TGT_W-1:0] out_tgt_r;
    logic [TGT_W-1:0] tgt_nx_s;
    operand_t         out_operand_r;
    logic             res_nx_s;
    logic             err_r;
    logic [15:0]      cnt_r;

    logic             cmp_res_s;
    logic             hs_s;
    logic             final_s;
    logic             in_ready_s;
    logic             acc_s;
    logic             legal_s;
    logic             acc_legal_s;

    pred_compare #(.DATA_W(DATA_W)) u_cmp (
        .op     (bus.in_op),
        .a      (bus.in_a),
        .b      (bus.in_b),
        .result (cmp_res_s)
    );

    // Handshake decode; a new test may enter while the last target is leaving.
    always_comb begin
        hs_s        = out_valid_r && bus.out_ready;
        final_s     = (state_r == ST_SEND1) || ((state_r == ST_SEND0) && !two_tgt_r);
        in_ready_s  = (state_r == ST_IDLE) || (final_s && bus.out_ready);
        acc_s       = bus.in_valid && in_ready_s;
        legal_s     = (bus.in_num_tgt == 2'd1) || (bus.in_num_tgt == 2'd2);
        acc_legal_s = acc_s && legal_s;
    end

    // Next-state logic; target counts 0 and 3 are consumed without output.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_legal_s) state_nx_s = ST_SEND0;
                else             state_nx_s = ST_IDLE;
            end
            ST_SEND0: begin
                if (hs_s) begin
                    if (two_tgt_r)        state_nx_s = ST_SEND1;
                    else if (acc_legal_s) state_nx_s = ST_SEND0;
                    else                  state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SEND0;
                end
            end
            ST_SEND1: begin
                if (hs_s) begin
                    if (acc_legal_s) state_nx_s = ST_SEND0;
                    else             state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SEND1;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next output payload: a fresh acceptance wins, then the SEND0->SEND1 step, else hold.
    always_comb begin
        tgt_nx_s = out_tgt_r;
        res_nx_s = out_operand_r.data[0];
        if (acc_legal_s) begin
            tgt_nx_s = bus.in_tgt0;
            res_nx_s = cmp_res_s;
        end else if ((state_r == ST_SEND0) && hs_s && two_tgt_r) begin
            tgt_nx_s = tgt1_r;
        end else begin
            tgt_nx_s = out_tgt_r;
        end
    end

    // State, latched targets and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            two_tgt_r     <= 1'b0;
            tgt1_r        <= '0;
            out_valid_r   <= 1'b0;
            out_tgt_r     <= '0;
            out_operand_r <= '0;
            err_r         <= 1'b0;
            cnt_r         <= 16'd0;
        end else begin
            state_r                 <= state_nx_s;
            out_valid_r             <= (state_nx_s != ST_IDLE);
            out_tgt_r               <= tgt_nx_s;
            out_operand_r.valid     <= (state_nx_s != ST_IDLE);
            out_operand_r.data      <= {{(EDGE_DATA_W-1){1'b0}}, res_nx_s};
            err_r                   <= acc_s && (bus.in_num_tgt == 2'd3);
            cnt_r                   <= cnt_r + {15'd0, hs_s};
            if (acc_legal_s) begin
                tgt1_r    <= bus.in_tgt1;
                two_tgt_r <= (bus.in_num_tgt == 2'd2);
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_tgt     = out_tgt_r;
    assign bus.out_operand = out_operand_r;
    assign err_illegal     = err_r;
    assign sent_cnt        = cnt_r;

endmodule

// File: doc/pred_generator.md
PRED_GENERATOR -- requirements
Module: pred_generator

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand data width.
REQ-002 SHALL have parameter TGT_W, default 8, target address width (reservation-station slot + operand-slot select).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  test instruction offered.
REQ-006 SHALL have port in_ready  output  1  test instruction accepted when in_valid&&in_ready.
REQ-007 SHALL have port in_op  input  test_op_e (3)  TEQ,TNE,TLT,TLE,TGT,TGE,TLTU,TGEU.
REQ-008 SHALL have ports in_a, in_b  input  DATA_W each  compare operands.
REQ-009 SHALL have port in_num_tgt  input  2  target count, 0..2; 3 is illegal.
REQ-010 SHALL have ports in_tgt0, in_tgt1  input  TGT_W each  predicate destinations.
REQ-011 SHALL have port out_valid  output  1  predicate operand offered to operand network.
REQ-012 SHALL have port out_ready  input  1  network accepts when out_valid&&out_ready.
REQ-013 SHALL have port out_tgt  output  TGT_W  destination of current predicate.
REQ-014 SHALL have port out_operand  output  operand_t  valid=1, data[0]=test result, data[DATA_W-1:1]=0.
REQ-015 SHALL have port err_illegal  output  1  one-cycle pulse on acceptance with in_num_tgt==3.
REQ-016 SHALL have port sent_cnt  output  16  count of completed output handshakes, wraps at 65535->0.

Function
REQ-017 Result SHALL be computed combinationally at acceptance and registered; TLT/TLE/TGT/TGE signed, TLTU/TGEU unsigned, TEQ/TNE bitwise equality.
REQ-018 FSM SHALL have states IDLE, SEND0, SEND1.
REQ-019 IDLE: in_ready=1; on accept with num_tgt 1 or 2 -> SEND0, latch result, tgt0, tgt1, num_tgt.
REQ-020 Accept with num_tgt==0 SHALL be consumed, produce no output, remain IDLE.
REQ-021 Accept with num_tgt==3 SHALL behave as num_tgt==0 and pulse err_illegal next cycle.
REQ-022 SEND0: out_valid=1, out_tgt=tgt0; on handshake -> SEND1 if num_tgt==2, else IDLE.
REQ-023 SEND1: out_valid=1, out_tgt=tgt1; on handshake -> IDLE.
REQ-024 First out_valid SHALL assert exactly one cycle after acceptance (latency 1).
REQ-025 out_tgt, out_operand SHALL hold stable while out_valid && !out_ready; out_valid SHALL not drop before handshake.
REQ-026 in_ready SHALL also be 1 during the final send state in the cycle out_ready=1, allowing back-to-back acceptance with no bubble; in_ready SHALL otherwise be 0 outside IDLE.
REQ-027 On simultaneous final handshake and new acceptance, FSM SHALL go directly to SEND0 (or IDLE for num_tgt 0/3) with new latched data.
REQ-028 sent_cnt SHALL increment by 1 per output handshake.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, out_valid=0, out_tgt=0, out_operand=0, err_illegal=0, sent_cnt=0; in_ready=1 after release.
REQ-030 Reset mid-SEND0/SEND1 SHALL discard pending predicates; none emitted after release.

Structure
REQ-031 operand_t (valid, data[DATA_W-1:0]) and test_op_e SHALL reside in shared package edge_pkg; no local redefinition.
REQ-032 Comparator SHALL be sub-module pred_compare (purely combinational: op, a, b -> result); FSM and registers in pred_generator.

Verification
REQ-033 TLT a=0xFFFFFFFF b=1, num_tgt=1 tgt0=0x12, out_ready=1 -> one cycle later out_valid, out_tgt=0x12, data=1; sent_cnt=1.
REQ-034 TLTU same operands, num_tgt=2 tgt0=0x05 tgt1=0x86 -> two consecutive outputs data=0 to 0x05 then 0x86; sent_cnt=2.
REQ-035 TEQ a=b=7, num_tgt=2, out_ready low 3 cycles -> out_tgt=tgt0, data=1 held 3 cycles, then tgt0, tgt1 sent.
REQ-036 Back-to-back: second TNE offered during final handshake -> accepted same cycle, its first output in following cycle, no gap.
REQ-037 num_tgt=3 -> no out_valid, err_illegal pulses 1 cycle; num_tgt=0 -> no output, no error.
REQ-038 rst_n asserted during SEND1 with out_ready=0 -> out_valid=0 immediately, sent_cnt=0, no output after release.
